vmulmax_sched: RTL

- Round-robin scheduler that shares one vmulmax pipeline (vvmul stage followed by vreducemax tree) among NUM_REQ requesters.
- Each cycle it accepts at most one request and drives that requester's operand vectors into the pipeline.
- A tag travels alongside each request through a delay line matching the pipeline depth, so each result returns to its originator.
- The pipeline has no stall; the scheduler is the only source of flow control.

---
 rtl/vmulmax_pkg.sv | 14 +
 rtl/vmulmax_sched_rr_arbiter.sv | 34 +++
 rtl/vmulmax_sched.sv | 87 ++++++++
 3 files changed

// File: rtl/vmulmax_pkg.sv
// vmulmax_pkg: shared lane/vector types and helpers for vmulmax-based schedulers.
package vmulmax_pkg;
  localparam int INT_SIZE_DEF = 16;
  localparam int VECTOR_SIZE_DEF = 16;
  localparam int MAX_REQ = 64;
  typedef logic [INT_SIZE_DEF-1:0] lane_t;
  typedef lane_t [VECTOR_SIZE_DEF-1:0] vec_t;
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction
  function automatic int pipe_latency(input int vs);
    return 1 + $clog2(vs);
  endfunction
endpackage

// File: rtl/vmulmax_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; the pointer moves past each winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0] grant_d;
  // Scan from lowest to highest priority so the last hit is the pointer-nearest request.
  always_comb begin
    int k;
    k = 0;
    grant_d = '0;
    ptr_d = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        grant_d = '0;
        grant_d[k] = 1'b1;
        ptr_d = PW'((k == N - 1) ? 0 : k + 1);
      end
    end
  end
  assign grant = resetn ? grant_d : '0;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/vmulmax_sched.sv
// vmulmax_sched: round-robin sharing of one vmulmax pipeline among NUM_REQ requesters.
// Optional per-requester grant counters when VMULMAX_SCHED_STATS_EN is defined.
module vmulmax_sched
  import vmulmax_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int VECTOR_SIZE = VECTOR_SIZE_DEF,
  parameter int INT_SIZE = INT_SIZE_DEF,
  parameter int PIPE_LATENCY = pipe_latency(VECTOR_SIZE)
) (
  input  logic                                          clock,
  input  logic                                          resetn,
`ifdef VMULMAX_SCHED_STATS_EN
  input  logic                                          stats_clear,
  output logic [NUM_REQ-1:0][31:0]                      grant_count,
`endif
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic [NUM_REQ-1:0][VECTOR_SIZE-1:0][INT_SIZE-1:0] req_a,
  input  logic [NUM_REQ-1:0][VECTOR_SIZE-1:0][INT_SIZE-1:0] req_x,
  output logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]          dp_a,
  output logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]          dp_x,
  input  logic [INT_SIZE-1:0]                           dp_y,
  output logic [NUM_REQ-1:0]                            resp_valid,
  output logic [INT_SIZE-1:0]                           resp_y
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef struct packed {
    logic          v;
    logic [IW-1:0] idx;
  } tag_t;
  logic [NUM_REQ-1:0] grant;
  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] a_d, x_d, a_q, x_q;
  logic [IW-1:0] idx_d;
  tag_t tag_d, tail;
  tag_t [PIPE_LATENCY:0] tag_q;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock (clock),
    .resetn(resetn),
    .req   (req_valid),
    .grant (grant)
  );
  assign req_ready = grant;
  always_comb begin
    a_d = '0;
    x_d = '0;
    idx_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_d = req_a[i];
        x_d = req_x[i];
        idx_d = IW'(i);
      end
    end
    tag_d.v = |grant;
    tag_d.idx = idx_d;
  end
  // Tail sits PIPE_LATENCY edges behind the launch register, aligned with dp_y.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_q <= '0;
      x_q <= '0;
      tag_q <= '0;
    end else begin
      a_q <= a_d;
      x_q <= x_d;
      tag_q <= {tag_q[PIPE_LATENCY-1:0], tag_d};
    end
  end
  assign dp_a = a_q;
  assign dp_x = x_q;
  assign tail = tag_q[PIPE_LATENCY];
  assign resp_valid = tail.v ? NUM_REQ'(onehot(int'(tail.idx))) : '0;
  assign resp_y = tail.v ? dp_y : '0;
`ifdef VMULMAX_SCHED_STATS_EN
  logic [NUM_REQ-1:0][31:0] cnt_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (stats_clear) cnt_q[i] <= '0;
        else if (grant[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
  end
  assign grant_count = cnt_q;
`else
`endif
endmodule
